// File: rtl/axis_xgmii_tx_64.sv
// AXI-stream to 64-bit XGMII transmit framer: inserts /S/ preamble, /T/ terminate,
// error codes on tuser/underflow, and enforces the minimum inter-frame gap.
module axis_xgmii_tx_64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  xgmii_clk_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic                  start_packet,
  output logic                  error_underflow
);

  localparam logic [DATA_WIDTH-1:0] IdleD  = 64'h0707070707070707;
  localparam logic [DATA_WIDTH-1:0] PreD   = 64'hD5555555555555FB;
  localparam logic [DATA_WIDTH-1:0] TermD  = 64'h07070707070707FD;
  localparam logic [DATA_WIDTH-1:0] UflowD = 64'hFDFEFEFEFEFEFEFE;
  localparam logic [CTRL_WIDTH-1:0] AllCtl = '1;

  typedef enum logic [2:0] {StIdle, StPayload, StTerm, StDrop, StIfg} state_e;

  state_e                r_state;
  logic [1:0]            r_ifg_cnt;
  logic [DATA_WIDTH-1:0] r_txd;
  logic [CTRL_WIDTH-1:0] r_txc;
  logic                  r_start;
  logic                  r_err;

  logic [3:0]            w_keep_cnt;
  logic [DATA_WIDTH-1:0] w_last_d;
  logic [CTRL_WIDTH-1:0] w_last_c;
  logic [1:0]            w_ifg_init;

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      w_keep_cnt = w_keep_cnt + 4'(s_axis_tkeep[i]);
    end
  end

  // Final word of a frame: data (or FE on error) then FD, padded with idles.
  always_comb begin
    w_last_d = '0;
    w_last_c = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (4'(i) < w_keep_cnt) begin
        w_last_d[8*i +: 8] = s_axis_tuser ? 8'hFE : s_axis_tdata[8*i +: 8];
        w_last_c[i]        = s_axis_tuser;
      end else if (4'(i) == w_keep_cnt) begin
        w_last_d[8*i +: 8] = 8'hFD;
        w_last_c[i]        = 1'b1;
      end else begin
        w_last_d[8*i +: 8] = 8'h07;
        w_last_c[i]        = 1'b1;
      end
    end
  end

  // Three or fewer trailing /T/+/I/ bytes need a second idle word to reach a 12-byte gap.
  assign w_ifg_init = (w_keep_cnt >= 4'd5) ? 2'd2 : 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_ifg_cnt <= '0;
      r_txd     <= IdleD;
      r_txc     <= AllCtl;
      r_start   <= 1'b0;
      r_err     <= 1'b0;
    end else if (!xgmii_clk_en) begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (s_axis_tvalid) begin
            r_txd   <= PreD;
            r_txc   <= 8'h01;
            r_start <= 1'b1;
            r_state <= StPayload;
          end else begin
            r_txd <= IdleD;
            r_txc <= AllCtl;
          end
        end
        StPayload: begin
          if (!s_axis_tvalid) begin
            r_txd   <= UflowD;
            r_txc   <= AllCtl;
            r_err   <= 1'b1;
            r_state <= StDrop;
          end else if (!s_axis_tlast) begin
            r_txd <= s_axis_tdata;
            r_txc <= '0;
          end else begin
            r_txd <= w_last_d;
            r_txc <= w_last_c;
            if (w_keep_cnt == 4'd8) begin
              r_state <= StTerm;
            end else begin
              r_ifg_cnt <= w_ifg_init;
              r_state   <= StIfg;
            end
          end
        end
        StTerm: begin
          r_txd     <= TermD;
          r_txc     <= AllCtl;
          r_ifg_cnt <= 2'd1;
          r_state   <= StIfg;
        end
        StDrop: begin
          r_txd <= IdleD;
          r_txc <= AllCtl;
          if (s_axis_tvalid && s_axis_tlast) begin
            r_ifg_cnt <= 2'd1;
            r_state   <= StIfg;
          end
        end
        StIfg: begin
          r_txd     <= IdleD;
          r_txc     <= AllCtl;
          r_ifg_cnt <= r_ifg_cnt - 2'd1;
          if (r_ifg_cnt <= 2'd1) begin
            r_ifg_cnt <= '0;
            r_state   <= StIdle;
          end
        end
        default: begin
          r_txd   <= IdleD;
          r_txc   <= AllCtl;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign s_axis_tready   = ((r_state == StPayload) || (r_state == StDrop)) && xgmii_clk_en;
  assign xgmii_txd       = r_txd;
  assign xgmii_txc       = r_txc;
  assign start_packet    = r_start;
  assign error_underflow = r_err;

endmodule

// File: tb/tb_axis_xgmii_tx_64.sv
// Bench for axis_xgmii_tx_64: random frames driven from a beat queue, output compared
// against a byte-stream model of the XGMII framing and inter-frame gap rules.
module tb_axis_xgmii_tx_64;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast, tuser;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic        sp, uf;

  always #5 clk = ~clk;

  axis_xgmii_tx_64 #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .xgmii_clk_en   (en),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tlast   (tlast),
    .s_axis_tuser   (tuser),
    .xgmii_txd      (txd),
    .xgmii_txc      (txc),
    .start_packet   (sp),
    .error_underflow(uf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Source beats; a hole entry withholds tvalid for one enabled cycle.
  logic [63:0] src_d[$];
  logic [7:0]  src_k[$];
  bit          src_l[$], src_u[$], src_h[$];

  // Expected enabled-cycle output words.
  logic [63:0] ew_d[$];
  logic [7:0]  ew_c[$];
  bit          ew_sp[$], ew_err[$];
  logic [7:0]  pb_d[$];
  bit          pb_c[$];
  bit          pend_sp, pend_err;

  // Per-cycle captures.
  bit          cap_en[$];
  logic [63:0] cap_d[$];
  logic [7:0]  cap_c[$];
  logic        cap_sp[$], cap_err[$], cap_rdy[$];

  task automatic put(input logic [7:0] d, input bit c);
    logic [63:0] wd;
    logic [7:0]  wc;
    pb_d.push_back(d);
    pb_c.push_back(c);
    if (pb_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        wd[8*i +: 8] = pb_d[i];
        wc[i]        = pb_c[i];
      end
      ew_d.push_back(wd);
      ew_c.push_back(wc);
      ew_sp.push_back(pend_sp);
      ew_err.push_back(pend_err);
      pend_sp  = 1'b0;
      pend_err = 1'b0;
      pb_d.delete();
      pb_c.delete();
    end
  endtask

  task automatic put_idle_word();
    for (int i = 0; i < 8; i++) put(8'h07, 1'b1);
  endtask

  // Queue one frame of len bytes; uf_at > 0 withholds tvalid after that many beats.
  task automatic add_frame(input int len, input bit user, input int uf_at, input bit rnd);
    logic [7:0]  b[$];
    logic [63:0] d;
    int          nb, nlast, gap;
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    nb    = (len + 7) / 8;
    nlast = len - 8 * (nb - 1);
    for (int k = 0; k < nb; k++) begin
      d = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) if (8 * k + i < len) d[8*i +: 8] = b[8*k+i];
      src_d.push_back(d);
      src_k.push_back((k == nb - 1) ? 8'((1 << nlast) - 1) : (rnd ? 8'($urandom) : 8'hFF));
      src_l.push_back(k == nb - 1);
      src_u.push_back((k == nb - 1) ? user : (rnd ? 1'($urandom) : 1'b0));
      src_h.push_back(1'b0);
      if (uf_at > 0 && k == uf_at - 1) begin
        src_d.push_back('0); src_k.push_back('0); src_l.push_back(1'b0);
        src_u.push_back(1'b0); src_h.push_back(1'b1);
      end
    end
    pend_sp = 1'b1;
    put(8'hFB, 1'b1);
    for (int i = 0; i < 6; i++) put(8'h55, 1'b0);
    put(8'hD5, 1'b0);
    if (uf_at > 0) begin
      for (int i = 0; i < 8 * uf_at; i++) put(b[i], 1'b0);
      pend_err = 1'b1;
      for (int i = 0; i < 7; i++) put(8'hFE, 1'b1);
      put(8'hFD, 1'b1);
      for (int i = 0; i < nb - uf_at + 1; i++) put_idle_word();
    end else begin
      for (int i = 0; i < len; i++) begin
        if (user && i >= len - nlast) put(8'hFE, 1'b1);
        else put(b[i], 1'b0);
      end
      put(8'hFD, 1'b1);
      gap = 1;
      while (pb_d.size() != 0) begin
        put(8'h07, 1'b1);
        gap++;
      end
      while (gap < 12) begin
        put_idle_word();
        gap += 8;
      end
    end
  endtask

  function automatic void clear_all();
    src_d.delete(); src_k.delete(); src_l.delete(); src_u.delete(); src_h.delete();
    ew_d.delete(); ew_c.delete(); ew_sp.delete(); ew_err.delete();
  endfunction

  // en_mode: 0 = always on, 1 = 1,0,1,0 pattern, 2 = random.
  task automatic run(input int n_en, input int en_mode);
    int  en_cnt = 0;
    int  cyc = 0;
    bit  fire;
    cap_en.delete(); cap_d.delete(); cap_c.delete();
    cap_sp.delete(); cap_err.delete(); cap_rdy.delete();
    while (en_cnt < n_en && cyc < 8 * n_en + 32) begin
      @(negedge clk);
      en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      if (src_d.size() > 0 && !src_h[0]) begin
        tvalid = 1'b1; tdata = src_d[0]; tkeep = src_k[0]; tlast = src_l[0]; tuser = src_u[0];
      end else begin
        tvalid = 1'b0; tdata = {$urandom, $urandom}; tkeep = 8'($urandom);
        tlast = 1'($urandom); tuser = 1'($urandom);
      end
      #1;
      fire = tvalid && tready;
      cap_rdy.push_back(tready);
      @(posedge clk);
      #1;
      cap_en.push_back(en); cap_d.push_back(txd); cap_c.push_back(txc);
      cap_sp.push_back(sp); cap_err.push_back(uf);
      if (fire) begin
        void'(src_d.pop_front()); void'(src_k.pop_front()); void'(src_l.pop_front());
        void'(src_u.pop_front()); void'(src_h.pop_front());
      end else if (en && src_h.size() > 0 && src_h[0]) begin
        void'(src_d.pop_front()); void'(src_k.pop_front()); void'(src_l.pop_front());
        void'(src_u.pop_front()); void'(src_h.pop_front());
      end
      if (en) en_cnt++;
      cyc++;
    end
    tvalid = 1'b0;
    en     = 1'b1;
    n_checks++;
    if (en_cnt < n_en) begin
      n_errors++;
      $display("FAIL run_timeout: got %0d enabled cycles want %0d", en_cnt, n_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; tvalid = 1'b1; tdata = '1; tkeep = '1; tlast = 1'b0; tuser = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (txd !== IDLE_W) begin n_errors++; $display("FAIL reset_txd: got %h want %h", txd, IDLE_W); end
    if (txc !== 8'hFF) begin n_errors++; $display("FAIL reset_txc: got %h want ff", txc); end
    if (tready !== 1'b0) begin n_errors++; $display("FAIL reset_tready: got %b want 0", tready); end
    if (sp !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b want 0", sp); end
    if (uf !== 1'b0) begin n_errors++; $display("FAIL reset_uflow: got %b want 0", uf); end
    rst = 1'b0; tvalid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_frames();
    int j; logic [63:0] ed, hd; logic [7:0] ec, hc; logic [1:0] es;
    clear_all();
    add_frame(64, 1'b0, 0, 1'b0);
    add_frame(61, 1'b0, 0, 1'b0);
    add_frame(62, 1'b0, 0, 1'b0);
    add_frame(60, 1'b1, 0, 1'b0);
    add_frame(68, 1'b0, 0, 1'b0);
    add_frame(64, 1'b0, 0, 1'b0);
    run(ew_d.size() + 3, 0);
    j = 0; hd = IDLE_W; hc = 8'hFF;
    for (int i = 0; i < cap_en.size(); i++) begin
      if (cap_en[i]) begin
        if (j < ew_d.size()) begin ed = ew_d[j]; ec = ew_c[j]; es = {ew_sp[j], ew_err[j]}; end
        else begin ed = IDLE_W; ec = 8'hFF; es = 2'b00; end
        j++; hd = ed; hc = ec;
      end else begin
        ed = hd; ec = hc; es = 2'b00;
      end
      n_checks += 2;
      if ({cap_d[i], cap_c[i]} !== {ed, ec}) begin
        n_errors++;
        $display("FAIL frames_word cyc %0d: got %h/%h want %h/%h", i, cap_d[i], cap_c[i], ed, ec);
      end
      if ({cap_sp[i], cap_err[i]} !== es) begin
        n_errors++;
        $display("FAIL frames_pulse cyc %0d: got %b%b want %b", i, cap_sp[i], cap_err[i], es);
      end
    end
  endtask

  task automatic test_underflow();
    int j; logic [63:0] ed, hd; logic [7:0] ec, hc; logic [1:0] es;
    clear_all();
    add_frame(48, 1'b0, 3, 1'b0);
    add_frame(30, 1'b0, 0, 1'b0);
    run(ew_d.size() + 3, 0);
    j = 0; hd = IDLE_W; hc = 8'hFF;
    for (int i = 0; i < cap_en.size(); i++) begin
      if (cap_en[i]) begin
        if (j < ew_d.size()) begin ed = ew_d[j]; ec = ew_c[j]; es = {ew_sp[j], ew_err[j]}; end
        else begin ed = IDLE_W; ec = 8'hFF; es = 2'b00; end
        j++; hd = ed; hc = ec;
      end else begin
        ed = hd; ec = hc; es = 2'b00;
      end
      n_checks += 2;
      if ({cap_d[i], cap_c[i]} !== {ed, ec}) begin
        n_errors++;
        $display("FAIL uflow_word cyc %0d: got %h/%h want %h/%h", i, cap_d[i], cap_c[i], ed, ec);
      end
      if ({cap_sp[i], cap_err[i]} !== es) begin
        n_errors++;
        $display("FAIL uflow_pulse cyc %0d: got %b%b want %b", i, cap_sp[i], cap_err[i], es);
      end
    end
  endtask

  task automatic test_clk_en(input int en_mode, input int n_frames);
    int j; logic [63:0] ed, hd; logic [7:0] ec, hc; logic [1:0] es;
    int len, nb;
    clear_all();
    if (en_mode == 1) begin
      add_frame(61, 1'b0, 0, 1'b0);
      add_frame(16, 1'b0, 0, 1'b0);
    end else begin
      for (int f = 0; f < n_frames; f++) begin
        len = $urandom_range(1, 90);
        nb  = (len + 7) / 8;
        if (nb >= 2 && $urandom_range(0, 4) == 0)
          add_frame(len, 1'b0, $urandom_range(1, nb - 1), 1'b1);
        else
          add_frame(len, ($urandom_range(0, 3) == 0), 0, 1'b1);
      end
    end
    run(ew_d.size() + 3, en_mode);
    j = 0; hd = IDLE_W; hc = 8'hFF;
    for (int i = 0; i < cap_en.size(); i++) begin
      if (cap_en[i]) begin
        if (j < ew_d.size()) begin ed = ew_d[j]; ec = ew_c[j]; es = {ew_sp[j], ew_err[j]}; end
        else begin ed = IDLE_W; ec = 8'hFF; es = 2'b00; end
        j++; hd = ed; hc = ec;
      end else begin
        ed = hd; ec = hc; es = 2'b00;
        n_checks++;
        if (cap_rdy[i] !== 1'b0) begin
          n_errors++;
          $display("FAIL en_tready cyc %0d: got %b want 0", i, cap_rdy[i]);
        end
      end
      n_checks += 2;
      if ({cap_d[i], cap_c[i]} !== {ed, ec}) begin
        n_errors++;
        $display("FAIL en%0d_word cyc %0d: got %h/%h want %h/%h", en_mode, i, cap_d[i], cap_c[i],
                 ed, ec);
      end
      if ({cap_sp[i], cap_err[i]} !== es) begin
        n_errors++;
        $display("FAIL en%0d_pulse cyc %0d: got %b%b want %b", en_mode, i, cap_sp[i], cap_err[i],
                 es);
      end
    end
  endtask

  task automatic test_reset_mid();
    int j; logic [63:0] ed, hd; logic [7:0] ec, hc; logic [1:0] es;
    clear_all();
    add_frame(40, 1'b0, 0, 1'b0);
    run(3, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; tvalid = 1'b1; tdata = src_d[0]; tkeep = src_k[0]; tlast = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; tvalid = 1'b0;
    n_checks += 4;
    if ({txd, txc} !== {IDLE_W, 8'hFF}) begin
      n_errors++;
      $display("FAIL rstmid_word: got %h/%h want %h/ff", txd, txc, IDLE_W);
    end
    if (tready !== 1'b0) begin n_errors++; $display("FAIL rstmid_tready: got %b want 0", tready); end
    if (sp !== 1'b0) begin n_errors++; $display("FAIL rstmid_start: got %b want 0", sp); end
    if (uf !== 1'b0) begin n_errors++; $display("FAIL rstmid_uflow: got %b want 0", uf); end
    clear_all();
    add_frame(21, 1'b0, 0, 1'b0);
    run(ew_d.size() + 3, 0);
    j = 0; hd = IDLE_W; hc = 8'hFF;
    for (int i = 0; i < cap_en.size(); i++) begin
      if (cap_en[i]) begin
        if (j < ew_d.size()) begin ed = ew_d[j]; ec = ew_c[j]; es = {ew_sp[j], ew_err[j]}; end
        else begin ed = IDLE_W; ec = 8'hFF; es = 2'b00; end
        j++; hd = ed; hc = ec;
      end else begin
        ed = hd; ec = hc; es = 2'b00;
      end
      n_checks += 2;
      if ({cap_d[i], cap_c[i]} !== {ed, ec}) begin
        n_errors++;
        $display("FAIL rstmid_after cyc %0d: got %h/%h want %h/%h", i, cap_d[i], cap_c[i], ed, ec);
      end
      if ({cap_sp[i], cap_err[i]} !== es) begin
        n_errors++;
        $display("FAIL rstmid_pulse cyc %0d: got %b%b want %b", i, cap_sp[i], cap_err[i], es);
      end
    end
  endtask

  initial begin
    pend_sp  = 1'b0;
    pend_err = 1'b0;
    test_reset();
    test_frames();
    test_underflow();
    test_clk_en(1, 0);
    test_clk_en(2, 14);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
